// File: rtl/uart_pkg.sv
// Constants, state encoding and baud-divider helper shared by the UART RX and TX blocks.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_e;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        int rate;
        rate = baud * oversample;
        return (clk_freq + rate / 2) / rate;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running mod-DIV divider producing a one-clock sample_tick on each wrap.
module uart_baud_tick #(
    parameter int DIV = 54
) (
    input  logic clk,
    input  logic rst_n,
    output logic sample_tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    // NOTE: sequential state is always updated with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_cnt == LAST);
            if (r_cnt == LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign sample_tick = r_tick;

endmodule

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver, LSB first, with oversampled mid-bit sampling and framing-error detection.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_done_tick,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int            DIV       = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int            TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

    logic                 w_sample_tick;
    logic                 w_rx_s;
    logic [1:0]           r_sync;
    uart_state_e          r_state,    w_state_nxt;
    logic [TW-1:0]        r_tick_cnt, w_tick_nxt;
    logic [2:0]           r_bit_cnt,  w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift,    w_shift_nxt;
    logic [DATA_BITS-1:0] r_data,     w_data_nxt;
    logic                 r_done,     w_done_nxt;
    logic                 r_err,      w_err_nxt;

    uart_baud_tick #(.DIV(DIV)) u_baud_tick (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (w_sample_tick)
    );

    // Synchronizer resets to the idle-line level so reset release is not seen as a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx};
        end
    end

    assign w_rx_s = r_sync[1];

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        if (w_sample_tick) begin
            unique case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        w_state_nxt = START;
                        w_tick_nxt  = '0;
                    end
                end
                START: begin
                    if (r_tick_cnt == MID_TICK) begin
                        if (w_rx_s) begin
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt = DATA;
                            w_tick_nxt  = '0;
                            w_bit_nxt   = '0;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_tick_cnt == LAST_TICK) begin
                        w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
                        w_tick_nxt  = '0;
                        if (r_bit_cnt == LAST_BIT) begin
                            w_state_nxt = STOP;
                        end else begin
                            w_bit_nxt = r_bit_cnt + 1'b1;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_tick_cnt == LAST_TICK) begin
                        w_tick_nxt = '0;
                        if (w_rx_s) begin
                            w_data_nxt  = r_shift;
                            w_done_nxt  = 1'b1;
                            w_state_nxt = IDLE;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = BREAK;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (w_rx_s) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_data     <= w_data_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign data_out     = r_data;
    assign rx_done_tick = r_done;
    assign frame_err    = r_err;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: DIV=10, 16x oversampling, so one bit is 160 clocks.
module tb_uart_rx_deserializer;

    localparam int BIT = 160;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_out;
    logic       rx_done_tick;
    logic       frame_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    int         cyc       = 0;
    int         done_cnt  = 0;
    int         err_cnt   = 0;
    int         both_cnt  = 0;
    int         wide_cnt  = 0;
    int         busy_cyc  = 0;
    int         last_done_cyc = 0;
    logic       prev_done = 1'b0;
    logic       prev_err  = 1'b0;
    logic [7:0] rx_q[$];

    uart_rx_deserializer #(
        .CLK_FREQ   (1_600_000),
        .BAUD       (10_000),
        .OVERSAMPLE (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .data_out     (data_out),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor, sampling on the falling edge away from register updates.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rx_done_tick === 1'b1) begin
            done_cnt = done_cnt + 1;
            rx_q.push_back(data_out);
            last_done_cyc = cyc;
        end
        if (frame_err === 1'b1) err_cnt = err_cnt + 1;
        if (rx_done_tick === 1'b1 && frame_err === 1'b1) both_cnt = both_cnt + 1;
        if ((rx_done_tick === 1'b1 && prev_done) || (frame_err === 1'b1 && prev_err))
            wide_cnt = wide_cnt + 1;
        if (busy === 1'b1) busy_cyc = busy_cyc + 1;
        prev_done = (rx_done_tick === 1'b1);
        prev_err  = (frame_err === 1'b1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val, input int bit_clks);
        rx = 1'b0;
        idle(bit_clks);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(bit_clks);
        end
        rx = stop_val;
        idle(bit_clks);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        idle(5);
        checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data got=%0h exp=00", data_out); end
        checks++; if (rx_done_tick !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", rx_done_tick); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", frame_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        idle(2 * BIT);
        checks++; if (busy_cyc !== 0 || done_cnt !== 0) begin failures++; $display("FAIL idle_after_reset busy_cyc=%0d done=%0d exp=0,0", busy_cyc, done_cnt); end
    endtask

    task automatic test_single_byte();
        int d0, e0, q0, t0;
        d0 = done_cnt; e0 = err_cnt; q0 = rx_q.size(); t0 = cyc;
        send_frame(8'hA5, 1'b1, BIT);
        idle(2 * BIT);
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL a5_done_count got=%0d exp=1", done_cnt - d0); end
        checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL a5_err_count got=%0d exp=0", err_cnt - e0); end
        checks++; if (data_out !== 8'hA5) begin failures++; $display("FAIL a5_data_out got=%0h exp=a5", data_out); end
        checks++; if (((rx_q.size() > q0) ? rx_q[q0] : 8'hxx) !== 8'hA5) begin failures++; $display("FAIL a5_tick_data exp=a5"); end
        checks++; if ((last_done_cyc - t0) < 9 * BIT || (last_done_cyc - t0) > 10 * BIT) begin
            failures++; $display("FAIL a5_latency got=%0d exp=%0d..%0d", last_done_cyc - t0, 9 * BIT, 10 * BIT);
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL a5_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        int d0, e0, q0;
        d0 = done_cnt; e0 = err_cnt; q0 = rx_q.size();
        send_frame(8'h04, 1'b1, BIT);
        send_frame(8'h41, 1'b1, BIT);
        idle(2 * BIT);
        checks++; if (done_cnt - d0 !== 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt - d0); end
        checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL b2b_err_count got=%0d exp=0", err_cnt - e0); end
        checks++; if (((rx_q.size() > q0) ? rx_q[q0] : 8'hxx) !== 8'h04) begin failures++; $display("FAIL b2b_first exp=04"); end
        checks++; if (((rx_q.size() > q0 + 1) ? rx_q[q0 + 1] : 8'hxx) !== 8'h41) begin failures++; $display("FAIL b2b_second exp=41"); end
        checks++; if (data_out !== 8'h41) begin failures++; $display("FAIL b2b_data_out got=%0h exp=41", data_out); end
    endtask

    task automatic test_glitch();
        int d0, e0, b0;
        d0 = done_cnt; e0 = err_cnt; b0 = busy_cyc;
        rx = 1'b0;
        idle(40);
        rx = 1'b1;
        idle(BIT - 40);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy got=%b exp=0", busy); end
        checks++; if (busy_cyc - b0 <= 0) begin failures++; $display("FAIL glitch_seen busy_cycles=%0d exp>0", busy_cyc - b0); end
        idle(BIT);
        checks++; if (done_cnt - d0 !== 0) begin failures++; $display("FAIL glitch_done got=%0d exp=0", done_cnt - d0); end
        checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL glitch_err got=%0d exp=0", err_cnt - e0); end
    endtask

    task automatic test_frame_error();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'h3C, 1'b0, BIT);
        rx = 1'b0;
        idle(3 * BIT);
        rx = 1'b1;
        idle(2 * BIT);
        checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", err_cnt - e0); end
        checks++; if (done_cnt - d0 !== 0) begin failures++; $display("FAIL ferr_done got=%0d exp=0", done_cnt - d0); end
        checks++; if (data_out !== 8'h41) begin failures++; $display("FAIL ferr_data_held got=%0h exp=41", data_out); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ferr_busy got=%b exp=0", busy); end
        send_frame(8'h55, 1'b1, BIT);
        idle(2 * BIT);
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL ferr_recover_done got=%0d exp=1", done_cnt - d0); end
        checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL ferr_recover_err got=%0d exp=1", err_cnt - e0); end
        checks++; if (data_out !== 8'h55) begin failures++; $display("FAIL ferr_recover_data got=%0h exp=55", data_out); end
    endtask

    task automatic test_reset_abort();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        rx = 1'b0;
        idle(BIT);
        rx = 1'b1;
        idle(4 * BIT + BIT / 2);
        rst_n = 1'b0;
        idle(20);
        checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL abort_reset_data got=%0h exp=00", data_out); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_reset_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        idle(5 * BIT);
        checks++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
            failures++; $display("FAIL abort_no_pulse done=%0d err=%0d exp=0,0", done_cnt - d0, err_cnt - e0);
        end
        send_frame(8'h12, 1'b1, BIT);
        idle(2 * BIT);
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL abort_after_done got=%0d exp=1", done_cnt - d0); end
        checks++; if (data_out !== 8'h12) begin failures++; $display("FAIL abort_after_data got=%0h exp=12", data_out); end
    endtask

    task automatic test_baud_skew();
        int d0, e0, q0;
        d0 = done_cnt; e0 = err_cnt; q0 = rx_q.size();
        send_frame(8'h96, 1'b1, 163);
        idle(BIT);
        send_frame(8'h69, 1'b1, 157);
        idle(2 * BIT);
        checks++; if (done_cnt - d0 !== 2) begin failures++; $display("FAIL skew_done got=%0d exp=2", done_cnt - d0); end
        checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL skew_err got=%0d exp=0", err_cnt - e0); end
        checks++; if (((rx_q.size() > q0) ? rx_q[q0] : 8'hxx) !== 8'h96) begin failures++; $display("FAIL skew_slow_byte exp=96"); end
        checks++; if (((rx_q.size() > q0 + 1) ? rx_q[q0 + 1] : 8'hxx) !== 8'h69) begin failures++; $display("FAIL skew_fast_byte exp=69"); end
    endtask

    task automatic test_pulse_shape();
        checks++; if (both_cnt !== 0) begin failures++; $display("FAIL pulse_exclusive got=%0d exp=0", both_cnt); end
        checks++; if (wide_cnt !== 0) begin failures++; $display("FAIL pulse_width got=%0d exp=0", wide_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_abort();
        test_baud_skew();
        test_pulse_shape();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
